// File: rtl/mem_access_ctrl.sv
// Memory access sequencer/arbiter: shares one MAR/MDR/memory port between
// instruction fetch (F) and load/store data (D) requesters.
//
// Ports:
//   clk, clr                 clock, asynchronous active-low reset
//   f_req/f_addr             fetch request (held until f_done) and address
//   f_rdata/f_done           fetch read data, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata data request, direction, address, write data
//   d_rdata/d_done           data read result, one-cycle completion pulse
//   err                      qualifies a done pulse: 1 = access timed out
//   mar_wr/mar_bus           MAR load enable and value
//   mdr_wr/mdr_bus           MDR load enable and value
//   mem_rd/mem_wr            memory strobes
//   mem_ready/mem_rdata      memory completion and read data
//   busy                     controller not idle
module mem_access_ctrl #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic [DATA_W-1:0] f_rdata,
   output logic              f_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              err,
   output logic              mar_wr,
   output logic [ADDR_W-1:0] mar_bus,
   output logic              mdr_wr,
   output logic [DATA_W-1:0] mdr_bus,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int unsigned      CNT_W    = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ADDR   = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_e;

   state_e             state_q,   state_d;
   logic               prio_q,    prio_d;     // 1 = D wins a tie
   logic               own_q,     own_d;      // 1 = D owns the transaction
   logic               we_q,      we_d;       // owner is a D write
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [DATA_W-1:0]  f_rdata_q, f_rdata_d;
   logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
   logic               f_done_q,  f_done_d;
   logic               d_done_q,  d_done_d;
   logic               err_q,     err_d;
   logic               mar_wr_q,  mar_wr_d;
   logic [ADDR_W-1:0]  mar_bus_q, mar_bus_d;
   logic               mdr_wr_q,  mdr_wr_d;
   logic [DATA_W-1:0]  mdr_bus_q, mdr_bus_d;
   logic               mem_rd_q,  mem_rd_d;
   logic               mem_wr_q,  mem_wr_d;
   logic               busy_q,    busy_d;
   logic               pick_d_c;

   // Next-state and next-output logic; outputs are decoded from the state
   // being entered so they appear registered in that state's cycle.
   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      own_d     = own_q;
      we_d      = we_q;
      cnt_d     = cnt_q;
      f_rdata_d = f_rdata_q;
      d_rdata_d = d_rdata_q;
      f_done_d  = 1'b0;
      d_done_d  = 1'b0;
      err_d     = 1'b0;
      mar_wr_d  = 1'b0;
      mar_bus_d = mar_bus_q;
      mdr_wr_d  = 1'b0;
      mdr_bus_d = mdr_bus_q;
      mem_rd_d  = 1'b0;
      mem_wr_d  = 1'b0;
      pick_d_c  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Round-robin: the pointer only matters when both requesters ask.
            if (f_req || d_req) begin
               pick_d_c = d_req && (!f_req || prio_q);
               own_d    = pick_d_c;
               we_d     = pick_d_c && d_we;
               prio_d   = !pick_d_c;
               state_d  = S_ADDR;
               mar_wr_d = 1'b1;
               mar_bus_d = pick_d_c ? d_addr : f_addr;
               if (pick_d_c && d_we) begin
                  mdr_wr_d  = 1'b1;
                  mdr_bus_d = d_wdata;
               end
            end
         end

         S_ADDR: begin
            state_d  = S_ACCESS;
            cnt_d    = '0;
            mem_rd_d = !we_q;
            mem_wr_d = we_q;
         end

         S_ACCESS: begin
            // Ready wins over a timeout landing in the same cycle.
            if (mem_ready) begin
               state_d  = S_RESP;
               f_done_d = !own_q;
               d_done_d = own_q;
               if (own_q) begin
                  d_rdata_d = we_q ? '0 : mem_rdata;
               end else begin
                  f_rdata_d = mem_rdata;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d  = S_RESP;
               f_done_d = !own_q;
               d_done_d = own_q;
               err_d    = 1'b1;
               if (own_q) begin
                  d_rdata_d = '0;
               end else begin
                  f_rdata_d = '0;
               end
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
               mem_rd_d = !we_q;
               mem_wr_d = we_q;
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= S_IDLE;
         prio_q    <= 1'b0;
         own_q     <= 1'b0;
         we_q      <= 1'b0;
         cnt_q     <= '0;
         f_rdata_q <= '0;
         d_rdata_q <= '0;
         f_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         err_q     <= 1'b0;
         mar_wr_q  <= 1'b0;
         mar_bus_q <= '0;
         mdr_wr_q  <= 1'b0;
         mdr_bus_q <= '0;
         mem_rd_q  <= 1'b0;
         mem_wr_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         prio_q    <= prio_d;
         own_q     <= own_d;
         we_q      <= we_d;
         cnt_q     <= cnt_d;
         f_rdata_q <= f_rdata_d;
         d_rdata_q <= d_rdata_d;
         f_done_q  <= f_done_d;
         d_done_q  <= d_done_d;
         err_q     <= err_d;
         mar_wr_q  <= mar_wr_d;
         mar_bus_q <= mar_bus_d;
         mdr_wr_q  <= mdr_wr_d;
         mdr_bus_q <= mdr_bus_d;
         mem_rd_q  <= mem_rd_d;
         mem_wr_q  <= mem_wr_d;
         busy_q    <= busy_d;
      end
   end

   assign f_rdata = f_rdata_q;
   assign f_done  = f_done_q;
   assign d_rdata = d_rdata_q;
   assign d_done  = d_done_q;
   assign err     = err_q;
   assign mar_wr  = mar_wr_q;
   assign mar_bus = mar_bus_q;
   assign mdr_wr  = mdr_wr_q;
   assign mdr_bus = mdr_bus_q;
   assign mem_rd  = mem_rd_q;
   assign mem_wr  = mem_wr_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. Expected behaviour comes from the
// transaction timing rules: request sampled at cycle 0, MAR load at cycle 1,
// strobe from cycle 2, done one cycle after ready or after TIMEOUT cycles.
module tb_mem_access_ctrl;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        f_req = 1'b0;
   logic [31:0] f_addr = '0;
   logic [31:0] f_rdata;
   logic        f_done;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        err;
   logic        mar_wr;
   logic [31:0] mar_bus;
   logic        mdr_wr;
   logic [31:0] mdr_bus;
   logic        mem_rd;
   logic        mem_wr;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        busy;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [31:0] exp_f = '0;
   logic [31:0] exp_d = '0;

   mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .clr(clr),
      .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done), .err(err),
      .mar_wr(mar_wr), .mar_bus(mar_bus), .mdr_wr(mdr_wr), .mdr_bus(mdr_bus),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One transaction from an idle controller, cycle by cycle.
   // k = ACCESS cycle index of mem_ready; k >= TO means no ready (timeout).
   task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int k, input bit drop, input string name);
      int         n_acc;
      int         done_c;
      bit         tmo;
      bit         wr;
      logic [7:0] exp_ctl;
      logic [7:0] got_ctl;
      tmo    = (k >= TO);
      n_acc  = tmo ? TO : k + 1;
      done_c = 2 + n_acc;
      wr     = is_d && we;
      for (int c = 0; c <= done_c; c++) begin
         exp_ctl = '0;
         if (c >= 1) exp_ctl[7] = 1'b1;
         if (c == 1) begin
            exp_ctl[6] = 1'b1;
            exp_ctl[5] = wr;
         end
         if (c >= 2 && c < done_c) begin
            exp_ctl[4] = !wr;
            exp_ctl[3] = wr;
         end
         if (c == done_c) begin
            exp_ctl[2] = !is_d;
            exp_ctl[1] = is_d;
            exp_ctl[0] = tmo;
            if (is_d) exp_d = (wr || tmo) ? 32'h0 : rdata;
            else      exp_f = tmo ? 32'h0 : rdata;
         end
         got_ctl = {busy, mar_wr, mdr_wr, mem_rd, mem_wr, f_done, d_done, err};
         tests_run++;
         if (got_ctl !== exp_ctl) begin
            $display("FAIL %s ctl cycle %0d: got %b want %b (busy,mar_wr,mdr_wr,mem_rd,mem_wr,f_done,d_done,err)",
                     name, c, got_ctl, exp_ctl);
            tests_failed++;
         end
         tests_run++;
         if ({f_rdata, d_rdata} !== {exp_f, exp_d}) begin
            $display("FAIL %s rdata cycle %0d: got f=%h d=%h want f=%h d=%h",
                     name, c, f_rdata, d_rdata, exp_f, exp_d);
            tests_failed++;
         end
         if (c == 1) begin
            tests_run++;
            if (mar_bus !== addr) begin
               $display("FAIL %s mar_bus: got %h want %h", name, mar_bus, addr);
               tests_failed++;
            end
            if (wr) begin
               tests_run++;
               if (mdr_bus !== wdata) begin
                  $display("FAIL %s mdr_bus: got %h want %h", name, mdr_bus, wdata);
                  tests_failed++;
               end
            end
         end
         if (c == 0) begin
            if (is_d) begin
               d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
            end else begin
               f_req = 1'b1; f_addr = addr;
            end
         end
         if (drop && c == 1) begin
            f_req = 1'b0; d_req = 1'b0;
         end
         if (c == done_c) begin
            f_req = 1'b0; d_req = 1'b0;
         end
         mem_ready = 1'b0;
         mem_rdata = $urandom();
         if (!tmo && c == 2 + k) begin
            mem_ready = 1'b1;
            mem_rdata = rdata;
         end else if (c < 2 || c == done_c) begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2 clr = 1'b0;
      #1;
      tests_run++;
      if ({busy, mar_wr, mdr_wr, mem_rd, mem_wr, f_done, d_done, err} !== 8'h00 ||
          {f_rdata, d_rdata, mar_bus, mdr_bus} !== 128'h0) begin
         $display("FAIL reset_outputs: got ctl=%b f=%h d=%h mar=%h mdr=%h want all 0",
                  {busy, mar_wr, mdr_wr, mem_rd, mem_wr, f_done, d_done, err},
                  f_rdata, d_rdata, mar_bus, mdr_bus);
         tests_failed++;
      end
      @(posedge clk); @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (busy !== 1'b0) begin
         $display("FAIL reset_idle: busy got %b want 0", busy);
         tests_failed++;
      end
      exp_f = '0;
      exp_d = '0;
   endtask

   task automatic test_single_fetch();
      run_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, "single_fetch");
   endtask

   task automatic test_data_write();
      run_txn(1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'hFFFF_0000, 2, 1'b0, "data_write");
   endtask

   task automatic test_timeout();
      run_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, TO, 1'b0, "timeout");
      run_txn(1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'hABCD_0123, TO + 3, 1'b0, "timeout_fetch");
   endtask

   task automatic test_timeout_tie();
      run_txn(1'b1, 1'b0, 32'h0000_0204, 32'h0, 32'h5A5A_A5A5, TO - 1, 1'b0, "timeout_tie");
   endtask

   task automatic test_random();
      int gap;
      for (int t = 0; t < 30; t++) begin
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            tests_run++;
            if ({busy, mar_wr, mdr_wr, mem_rd, mem_wr, f_done, d_done, err} !== 8'h00) begin
               $display("FAIL random_gap: got ctl=%b want 00000000",
                        {busy, mar_wr, mdr_wr, mem_rd, mem_wr, f_done, d_done, err});
               tests_failed++;
            end
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom();
            @(posedge clk); #1;
         end
         mem_ready = 1'b0;
         run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                 $urandom(), $urandom(), int'($urandom_range(0, TO + 2)),
                 1'($urandom_range(0, 1)), "random");
      end
   endtask

   // Both requesters held from reset release with immediate ready.
   task automatic test_back_to_back();
      logic [31:0] rd_prev;
      logic [7:0]  exp_ctl;
      logic [7:0]  got_ctl;
      int          nf;
      int          nd;
      int          p;
      bit          own_d;
      rd_prev = '0;
      nf = 0;
      nd = 0;
      clr = 1'b0;
      @(posedge clk); #1;
      clr = 1'b1;
      exp_f = '0;
      exp_d = '0;
      f_addr = $urandom();
      d_addr = $urandom();
      d_we = 1'b0;
      f_req = 1'b1;
      d_req = 1'b1;
      mem_ready = 1'b1;
      for (int c = 0; c <= 16; c++) begin
         p = c % 4;
         own_d = ((c / 4) % 2) == 1;
         exp_ctl = '0;
         if (p != 0) exp_ctl[7] = 1'b1;
         if (p == 1) exp_ctl[6] = 1'b1;
         if (p == 2) exp_ctl[4] = 1'b1;
         if (p == 3) begin
            exp_ctl[2] = !own_d;
            exp_ctl[1] = own_d;
            if (own_d) exp_d = rd_prev;
            else       exp_f = rd_prev;
         end
         got_ctl = {busy, mar_wr, mdr_wr, mem_rd, mem_wr, f_done, d_done, err};
         tests_run++;
         if (got_ctl !== exp_ctl) begin
            $display("FAIL back_to_back ctl cycle %0d: got %b want %b", c, got_ctl, exp_ctl);
            tests_failed++;
         end
         tests_run++;
         if ({f_rdata, d_rdata} !== {exp_f, exp_d}) begin
            $display("FAIL back_to_back rdata cycle %0d: got f=%h d=%h want f=%h d=%h",
                     c, f_rdata, d_rdata, exp_f, exp_d);
            tests_failed++;
         end
         if (p == 1) begin
            tests_run++;
            if (mar_bus !== (own_d ? d_addr : f_addr)) begin
               $display("FAIL back_to_back grant order cycle %0d: mar_bus got %h want %h",
                        c, mar_bus, own_d ? d_addr : f_addr);
               tests_failed++;
            end
         end
         nf += int'(f_done);
         nd += int'(d_done);
         if (c == 15) begin
            f_req = 1'b0;
            d_req = 1'b0;
         end
         mem_rdata = $urandom();
         if (p == 2) rd_prev = mem_rdata;
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      tests_run++;
      if (nf != 2 || nd != 2) begin
         $display("FAIL back_to_back done count: got f=%0d d=%0d want f=2 d=2", nf, nd);
         tests_failed++;
      end
   endtask

   task automatic test_reset_mid_access();
      d_req = 1'b1;
      d_we = 1'b1;
      d_addr = 32'h0000_0400;
      d_wdata = 32'h8765_4321;
      mem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
      end
      tests_run++;
      if (mem_wr !== 1'b1) begin
         $display("FAIL reset_mid_access pre: mem_wr got %b want 1", mem_wr);
         tests_failed++;
      end
      #3 clr = 1'b0;
      #1;
      tests_run++;
      if ({busy, mar_wr, mdr_wr, mem_rd, mem_wr, f_done, d_done, err} !== 8'h00 ||
          {f_rdata, d_rdata, mar_bus, mdr_bus} !== 128'h0) begin
         $display("FAIL reset_mid_access async: got ctl=%b f=%h d=%h mar=%h mdr=%h want all 0",
                  {busy, mar_wr, mdr_wr, mem_rd, mem_wr, f_done, d_done, err},
                  f_rdata, d_rdata, mar_bus, mdr_bus);
         tests_failed++;
      end
      d_req = 1'b0;
      exp_f = '0;
      exp_d = '0;
      @(posedge clk); #1;
      clr = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tests_run++;
         if ({busy, mar_wr, mdr_wr, mem_rd, mem_wr, f_done, d_done, err} !== 8'h00) begin
            $display("FAIL reset_mid_access after cycle %0d: got ctl=%b want 00000000",
                     c, {busy, mar_wr, mdr_wr, mem_rd, mem_wr, f_done, d_done, err});
            tests_failed++;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_data_write();
      test_timeout();
      test_timeout_tie();
      test_random();
      test_back_to_back();
      test_reset_mid_access();
      test_single_fetch();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory access sequencer and arbiter for the CPU datapath.
- Shares one memory port and its address register (MAR) and data register (MDR) between two requesters: instruction fetch (F) and load/store data (D).
- Per transaction: load MAR from the selected requester's address, load MDR for writes, strobe memory, wait for ready, return data with a done pulse.
- Sits between the control unit's fetch/execute logic and the MAR/MDR/memory interface.

Parameters:
- ADDR_W, 32, address width (matches MAR width)
- DATA_W, 32, data width
- TIMEOUT, 15, maximum ACCESS-state cycles before an error completion (1..255)

Ports:
- clk  in  1  clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-low
- f_req  in  1  fetch request, held until f_done
- f_addr  in  ADDR_W  fetch address
- f_rdata  out  DATA_W  fetch read data, valid when f_done=1
- f_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held until d_done
- d_we  in  1  data write (1) / read (0)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write value
- d_rdata  out  DATA_W  data read result, valid when d_done=1
- d_done  out  1  one-cycle data completion pulse
- err  out  1  qualifies the done pulse: 1 = timeout
- mar_wr  out  1  MAR write enable
- mar_bus  out  ADDR_W  value presented to MAR
- mdr_wr  out  1  MDR write enable
- mdr_bus  out  DATA_W  value presented to MDR
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_ready  in  1  memory completion
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (clr=0, async):
  - State IDLE, priority pointer = F.
  - All outputs 0, including rdata buses, mar_bus and mdr_bus.
  - An in-flight transaction is abandoned: no done is issued, and memory strobes drop immediately.
- States: IDLE -> ADDR -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Requests are sampled only here.
  - If exactly one req is high, grant it.
  - If both are high, grant the side named by the priority pointer.
  - Pointer flips to the other side after every grant (round-robin).
  - Store the granted owner and the d_we value; go to ADDR.
- ADDR (1 cycle):
  - mar_wr=1, mar_bus = owner's address.
  - For a D write: mdr_wr=1, mdr_bus=d_wdata. Otherwise mdr_wr=0.
  - Go to ACCESS.
- ACCESS:
  - mem_rd=1 for a fetch or a D read; mem_wr=1 for a D write. Never both.
  - The wait counter starts at 0 on entry and increments each cycle.
  - mem_ready=1: capture mem_rdata (reads only), err_next=0, go to RESP.
  - Otherwise, when counter == TIMEOUT-1 with no ready: err_next=1, captured data = 0, go to RESP.
  - mem_ready in the same cycle as the timeout takes precedence (normal completion).
- RESP (1 cycle):
  - Owner's done=1, err = err_next, owner's rdata = captured data.
  - For a write, rdata = 0.
  - Next state is IDLE; the next grant happens no earlier than the following cycle.
- rdata outputs hold their value until the next completion for the same owner or reset.
- Latency:
  - Request sampled in IDLE at cycle 0: mar_wr at cycle 1, strobe from cycle 2.
  - mem_ready at cycle 2+k gives done at cycle 3+k.
  - Minimum request-to-done is 3 cycles; back-to-back issue interval is 4 cycles.
- mem_ready outside ACCESS is ignored.
- Requester deasserting req mid-transaction: the transaction completes anyway and done still pulses.
- done pulses exactly once per grant; f_done and d_done are never high together.

Test Plan:
- Reset mid-ACCESS: assert clr=0 during a D write in ACCESS -> mem_wr drops asynchronously, no d_done, all outputs 0, state IDLE after release.
- Single fetch: f_req=1, f_addr=0x0000_0040, mem_ready on the 1st ACCESS cycle with mem_rdata=0xDEAD_BEEF -> mar_wr at cycle 1 with mar_bus=0x40; mem_rd at cycle 2; f_done=1, f_rdata=0xDEADBEEF, err=0 at cycle 3.
- Data write: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x1234_5678, ready after 3 ACCESS cycles:
  - ADDR cycle has mar_wr=1, mdr_wr=1, mdr_bus=0x12345678.
  - mem_wr high for 3 cycles, mem_rd stays 0.
  - d_done at cycle 5, d_rdata=0.
- Contention: f_req and d_req both held from reset release -> grants F, D, F, D in order; each done pulses once per grant; done pulses spaced exactly 4 cycles apart with immediate ready.
- Timeout: D read, mem_ready held 0, TIMEOUT=15 -> mem_rd high exactly 15 cycles, then d_done=1 with err=1 and d_rdata=0.
- Timeout tie: mem_ready=1 on the 15th ACCESS cycle -> err=0, data captured.
